// File: rtl/vga_scanout.sv
// vga_scanout: frame-buffer reader and VGA timing generator.
// Latches the frame base at frame start, fetches one pixel per visible clock from the video
// SRAM read port, and aligns colour/sync/data-enable with the SRAM read latency.
// Ports:
//   clk, rst            pixel clock, synchronous active-high reset
//   vga_base_address_i  frame buffer base, sampled at frame start only
//   ram_addr_o, ram_oe_n_o, ram_we_n_o, ram_din_o   SRAM read request
//   ram_result_i        SRAM read data (low 9 bits are the pixel colour)
//   vga_color_o         {R[2:0], G[2:0], B[2:0]}, 0 outside the visible region
//   hsync_o, vsync_o    sync outputs, SYNC_ACTIVE during the pulse
//   de_o                high for visible pixels
//   paint_done_o        one-cycle pulse at the start of vertical blanking
module vga_scanout #(
    parameter int unsigned H_VISIBLE    = 800,
    parameter int unsigned H_FRONT      = 56,
    parameter int unsigned H_SYNC       = 120,
    parameter int unsigned H_BACK       = 64,
    parameter int unsigned V_VISIBLE    = 600,
    parameter int unsigned V_FRONT      = 37,
    parameter int unsigned V_SYNC       = 6,
    parameter int unsigned V_BACK       = 23,
    parameter bit          SYNC_ACTIVE  = 1'b1,
    parameter int unsigned READ_LATENCY = 2,   // must be >= 1
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned DATA_W       = 16   // must be > 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] vga_base_address_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_oe_n_o,
    output logic              ram_we_n_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_result_i,
    output logic [8:0]        vga_color_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              de_o,
    output logic              paint_done_o
);

    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    // Stage READ_LATENCY of the shift registers is the counter term delayed by READ_LATENCY+1,
    // which lines up with valid SRAM data; the output register adds the final cycle.
    localparam int unsigned TAP      = READ_LATENCY;

    logic [HW-1:0]      h_q, h_d;
    logic [VW-1:0]      v_q, v_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d, cur_ptr;
    logic [ADDR_W-1:0]  addr_q;
    logic               oe_n_q;
    logic [TAP:0]       vis_sr_q, hs_sr_q, vs_sr_q;
    logic [8:0]         color_q;
    logic               de_q, hsync_q, vsync_q, paint_done_q;

    logic h_last, v_last, frame_start, visible, hs_raw, vs_raw, blank_start;

    always_comb begin
        h_last      = (h_q == HW'(H_TOTAL - 1));
        v_last      = (v_q == VW'(V_TOTAL - 1));
        h_d         = h_last ? '0 : h_q + HW'(1);
        v_d         = v_q;
        if (h_last) begin
            v_d = v_last ? '0 : v_q + VW'(1);
        end
        frame_start = (h_q == '0) && (v_q == '0);
        blank_start = (h_q == '0) && (v_q == VW'(V_VISIBLE));
        visible     = (h_q < HW'(H_VISIBLE)) && (v_q < VW'(V_VISIBLE));
        hs_raw      = (h_q >= HW'(HS_START)) && (h_q < HW'(HS_END));
        vs_raw      = (v_q >= VW'(VS_START)) && (v_q < VW'(VS_END));
        // The frame-start reload wins over the running pointer; pixel (0,0) fetches the base.
        cur_ptr     = frame_start ? vga_base_address_i : ptr_q;
        ptr_d       = visible ? cur_ptr + ADDR_W'(1) : cur_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q          <= '0;
            v_q          <= '0;
            ptr_q        <= '0;
            addr_q       <= '0;
            oe_n_q       <= 1'b1;
            vis_sr_q     <= '0;
            hs_sr_q      <= '0;
            vs_sr_q      <= '0;
            color_q      <= '0;
            de_q         <= 1'b0;
            hsync_q      <= ~SYNC_ACTIVE;
            vsync_q      <= ~SYNC_ACTIVE;
            paint_done_q <= 1'b0;
        end else begin
            h_q          <= h_d;
            v_q          <= v_d;
            ptr_q        <= ptr_d;
            if (visible) begin
                addr_q <= cur_ptr;
            end
            oe_n_q       <= ~visible;
            vis_sr_q     <= {vis_sr_q[TAP-1:0], visible};
            hs_sr_q      <= {hs_sr_q[TAP-1:0], hs_raw};
            vs_sr_q      <= {vs_sr_q[TAP-1:0], vs_raw};
            color_q      <= vis_sr_q[TAP] ? ram_result_i[8:0] : 9'd0;
            de_q         <= vis_sr_q[TAP];
            hsync_q      <= hs_sr_q[TAP] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_q      <= vs_sr_q[TAP] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            paint_done_q <= blank_start;
        end
    end

    // Only the colour bits of the read data are used.
    logic unused_result;
    assign unused_result = ^ram_result_i[DATA_W-1:9];

    assign ram_addr_o   = addr_q;
    assign ram_oe_n_o   = oe_n_q;
    assign ram_we_n_o   = 1'b1;
    assign ram_din_o    = '0;
    assign vga_color_o  = color_q;
    assign hsync_o      = hsync_q;
    assign vsync_o      = vsync_q;
    assign de_o         = de_q;
    assign paint_done_o = paint_done_q;

endmodule
